// File: rtl/decode_pkg.sv
// decode_pkg: RV32I opcodes, ALU op encodings, instruction classes and the ID/EX control payload
package decode_pkg;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  typedef enum logic [3:0] {
    CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BRANCH, CL_LOAD, CL_STORE, CL_OPIMM, CL_OP, CL_ILLEGAL
  } iclass_t;
  typedef enum logic {RUN, HALT} state_t;
  typedef struct packed {
    logic [4:0] rdn;
    logic [4:0] rs1n;
    logic [4:0] rs2n;
    logic [2:0] funct3;
    logic [3:0] alu_op;
    logic src_imm;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_lui;
    logic is_auipc;
    logic wbe;
    logic illegal;
  } idex_ctl_t;
  function automatic iclass_t classify(input logic [6:0] opc);
    case (opc)
      OPC_LUI: return CL_LUI;
      OPC_AUIPC: return CL_AUIPC;
      OPC_JAL: return CL_JAL;
      OPC_JALR: return CL_JALR;
      OPC_BRANCH: return CL_BRANCH;
      OPC_LOAD: return CL_LOAD;
      OPC_STORE: return CL_STORE;
      OPC_OPIMM: return CL_OPIMM;
      OPC_OP: return CL_OP;
      default: return CL_ILLEGAL;
    endcase
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended I/S/B/U/J immediate of an RV32I instruction (0 for OP and illegal)
//   instr : instruction word
//   imm   : immediate, sign-extended to WordSize
module imm_gen import decode_pkg::*; #(
  parameter int WordSize = 32
) (
  input  logic [31:0]         instr,
  output logic [WordSize-1:0] imm
);
  logic [6:0] opc;
  logic [31:0] imm32;
  assign opc = instr[6:0];
  always_comb
    imm32 = (opc == OPC_JALR || opc == OPC_LOAD || opc == OPC_OPIMM) ? {{20{instr[31]}}, instr[31:20]} :
            (opc == OPC_STORE) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            (opc == OPC_BRANCH) ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
            (opc == OPC_LUI || opc == OPC_AUIPC) ? {instr[31:12], 12'b0} :
            (opc == OPC_JAL) ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
            32'd0;
  assign imm = WordSize'($signed(imm32));
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with ID/EX register, load-use bubbles, backpressure and halt-on-illegal
//   in_valid/in_ready/in_instr/in_pc : fetch handshake
//   flush                           : redirect from EX, kills ID/EX and leaves HALT
//   ex_ready                        : EX consumes the ID/EX entry
//   rs1n/rs2n                       : GPR read addresses, aligned with the registered outputs
//   out_*                           : ID/EX payload
module decode_stage import decode_pkg::*; #(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [WordSize-1:0] in_pc,
  input  logic                flush,
  input  logic                ex_ready,
  output logic [4:0]          rs1n,
  output logic [4:0]          rs2n,
  output logic                out_valid,
  output logic [WordSize-1:0] out_pc,
  output logic [WordSize-1:0] out_imm,
  output logic [4:0]          out_rdn,
  output logic [4:0]          out_rs1n,
  output logic [4:0]          out_rs2n,
  output logic [2:0]          out_funct3,
  output logic [3:0]          out_alu_op,
  output logic                out_src_imm,
  output logic                out_is_load,
  output logic                out_is_store,
  output logic                out_is_branch,
  output logic                out_is_jal,
  output logic                out_is_jalr,
  output logic                out_is_lui,
  output logic                out_is_auipc,
  output logic                out_wbe,
  output logic                out_illegal
);
  state_t state;
  iclass_t cls;
  idex_ctl_t ctl, dec;
  logic [WordSize-1:0] imm;
  logic rs1_used, rs2_used, alt, advance, hazard, accept;
  imm_gen #(.WordSize(WordSize)) u_imm (.instr(in_instr), .imm(imm));
  assign cls = classify(in_instr[6:0]);
  assign rs1_used = !(cls inside {CL_LUI, CL_AUIPC, CL_JAL});
  assign rs2_used = cls inside {CL_BRANCH, CL_STORE, CL_OP};
  assign alt = in_instr[30] && (cls == CL_OP || (cls == CL_OPIMM && in_instr[14:12] == 3'b101));
  always_comb begin
    dec = '0;
    dec.rdn = in_instr[11:7];
    dec.rs1n = in_instr[19:15];
    dec.rs2n = in_instr[24:20];
    dec.funct3 = in_instr[14:12];
    dec.alu_op = (cls == CL_OP || cls == CL_OPIMM) ? {alt, in_instr[14:12]} : ALU_ADD;
    dec.src_imm = !(cls inside {CL_OP, CL_BRANCH, CL_ILLEGAL});
    dec.is_load = cls == CL_LOAD;
    dec.is_store = cls == CL_STORE;
    dec.is_branch = cls == CL_BRANCH;
    dec.is_jal = cls == CL_JAL;
    dec.is_jalr = cls == CL_JALR;
    dec.is_lui = cls == CL_LUI;
    dec.is_auipc = cls == CL_AUIPC;
    dec.wbe = in_instr[11:7] != 5'd0 && !(cls inside {CL_BRANCH, CL_STORE, CL_ILLEGAL});
    dec.illegal = cls == CL_ILLEGAL;
  end
  assign advance = !out_valid || ex_ready;
  // a load in ID/EX cannot forward to the instruction right behind it
  assign hazard = in_valid && out_valid && ctl.is_load && ctl.rdn != 5'd0 &&
                  ((rs1_used && in_instr[19:15] == ctl.rdn) || (rs2_used && in_instr[24:20] == ctl.rdn));
  assign in_ready = state == RUN && advance && !hazard && !flush;
  assign accept = in_valid && in_ready;
  // while stalled, keep addressing the held entry so GPR data stays aligned with ID/EX
  assign rs1n = advance ? in_instr[19:15] : ctl.rs1n;
  assign rs2n = advance ? in_instr[24:20] : ctl.rs2n;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= RUN;
      out_valid <= 1'b0;
      ctl <= '0;
      out_pc <= '0;
      out_imm <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      state <= RUN;
    end else if (advance) begin
      out_valid <= accept;
      if (accept) begin
        ctl <= dec;
        out_pc <= in_pc;
        out_imm <= imm;
        state <= dec.illegal ? HALT : state;
      end
    end
  assign out_rdn = ctl.rdn;
  assign out_rs1n = ctl.rs1n;
  assign out_rs2n = ctl.rs2n;
  assign out_funct3 = ctl.funct3;
  assign out_alu_op = ctl.alu_op;
  assign out_src_imm = ctl.src_imm;
  assign out_is_load = ctl.is_load;
  assign out_is_store = ctl.is_store;
  assign out_is_branch = ctl.is_branch;
  assign out_is_jal = ctl.is_jal;
  assign out_is_jalr = ctl.is_jalr;
  assign out_is_lui = ctl.is_lui;
  assign out_is_auipc = ctl.is_auipc;
  assign out_wbe = ctl.wbe;
  assign out_illegal = ctl.illegal;
endmodule
